// File: rtl/tec_busoff_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tec_busoff_pkg
//  Brief   : Shared state encoding and thresholds for the TEC / bus-off block.
//  Revision: 1.0
// ============================================================================
package tec_busoff_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL         = 2'b00,
      ST_BUSOFF_WAIT    = 2'b01,
      ST_BUSOFF_RECOVER = 2'b10
   } tec_state_t;

   localparam logic [8:0] c_TH_WARN    = 9'd96;
   localparam logic [8:0] c_TH_PASSIVE = 9'd128;
   localparam logic [8:0] c_TH_BUSOFF  = 9'd256;
   localparam logic [8:0] c_INC_STEP   = 9'd8;

endpackage : tec_busoff_pkg
`default_nettype wire

// File: rtl/tec_busoff_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : busoff_seq_cnt
//  Brief   : Counts runs of RUN_LEN recessive bits; flags the SEQ_LEN-th run.
//  Revision: 1.0
// ============================================================================
module busoff_seq_cnt #(
   parameter int RUN_LEN = 11,
   parameter int SEQ_LEN = 128
) (
   input  logic clock,
   input  logic i_enable,
   input  logic i_clear,
   input  logic i_bit_tick,
   input  logic i_rx_bit,
   output logic o_done
);

   logic [3:0] r_run;
   logic [7:0] r_seq;
   logic       w_step;
   logic       w_run_full;
   logic       w_seq_last;

   assign w_step     = i_enable & i_bit_tick;
   assign w_run_full = (r_run == 4'(RUN_LEN - 1));
   assign w_seq_last = (r_seq == 8'(SEQ_LEN - 1));
   assign o_done     = w_step & i_rx_bit & w_run_full & w_seq_last;

   always_ff @(posedge clock) begin
      if (i_clear || o_done) begin
         r_run <= 4'd0;
         r_seq <= 8'd0;
      end else if (w_step) begin
         if (!i_rx_bit) begin
            r_run <= 4'd0;
         end else if (w_run_full) begin
            r_run <= 4'd0;
            r_seq <= r_seq + 8'd1;
         end else begin
            r_run <= r_run + 4'd1;
         end
      end
   end

endmodule : busoff_seq_cnt
`default_nettype wire

// File: rtl/tec_busoff.sv
`default_nettype none
// ============================================================================
//  Module  : tec_busoff
//  Brief   : Transmit error counter with threshold flags and bus-off recovery.
//  Revision: 1.0
// ============================================================================
module tec_busoff
   import tec_busoff_pkg::*;
#(
   parameter int RUN_LEN = 11,
   parameter int SEQ_LEN = 128
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       incegttec,
   input  logic       dectec,
   input  logic       start_recover,
   input  logic       bit_tick,
   input  logic       rx_bit,
   output logic       tec_lt96,
   output logic       tec_ge96,
   output logic       tec_ge128,
   output logic       busoff,
   output logic       busoff_done,
   output logic [7:0] teccount
);

   tec_state_t r_state;
   logic [8:0] r_count;
   logic       r_mark;
   logic       r_busoff;
   logic       r_done;

   logic       w_action;
   logic       w_first;
   logic [8:0] w_inc_sum;
   logic       w_seq_enable;
   logic       w_seq_clear;
   logic       w_seq_done;

   assign w_action     = incegttec | dectec;
   assign w_first      = w_action & ~r_mark;
   // Only evaluated in NORMAL where r_count <= 255, so the sum cannot overflow 9 bits
   assign w_inc_sum    = r_count + c_INC_STEP;
   assign w_seq_enable = (r_state == ST_BUSOFF_RECOVER) & start_recover;
   assign w_seq_clear  = ~reset | ~w_seq_enable;

   busoff_seq_cnt #(
      .RUN_LEN (RUN_LEN),
      .SEQ_LEN (SEQ_LEN)
   ) u_seq_cnt (
      .clock      (clock),
      .i_enable   (w_seq_enable),
      .i_clear    (w_seq_clear),
      .i_bit_tick (bit_tick),
      .i_rx_bit   (rx_bit),
      .o_done     (w_seq_done)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state  <= ST_NORMAL;
         r_count  <= 9'd0;
         r_mark   <= 1'b0;
         r_busoff <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_mark <= w_action;
         r_done <= 1'b0;
         case (r_state)
            ST_NORMAL: begin
               if (w_first) begin
                  if (incegttec) begin
                     if (w_inc_sum >= c_TH_BUSOFF) begin
                        r_count  <= c_TH_BUSOFF;
                        r_state  <= ST_BUSOFF_WAIT;
                        r_busoff <= 1'b1;
                     end else begin
                        r_count <= w_inc_sum;
                     end
                  end else if (r_count != 9'd0) begin
                     r_count <= r_count - 9'd1;
                  end
               end
            end
            ST_BUSOFF_WAIT: begin
               if (start_recover) r_state <= ST_BUSOFF_RECOVER;
            end
            ST_BUSOFF_RECOVER: begin
               if (!start_recover) begin
                  r_state <= ST_BUSOFF_WAIT;
               end else if (w_seq_done) begin
                  r_state  <= ST_NORMAL;
                  r_count  <= 9'd0;
                  r_busoff <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_NORMAL;
               r_busoff <= 1'b0;
            end
         endcase
      end
   end

   assign tec_lt96    = (r_count < c_TH_WARN);
   assign tec_ge96    = (r_count >= c_TH_WARN);
   assign tec_ge128   = (r_count >= c_TH_PASSIVE);
   assign busoff      = r_busoff;
   assign busoff_done = r_done;
   assign teccount    = r_count[7:0];

endmodule : tec_busoff
`default_nettype wire

// File: tb/tb_tec_busoff.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tec_busoff
//  Brief   : Self-checking bench for tec_busoff against a behavioural model.
//  Revision: 1.0
// ============================================================================
module tb_tec_busoff;

   localparam int RUN_LEN = 11;
   localparam int SEQ_LEN = 128;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       incegttec = 1'b0;
   logic       dectec = 1'b0;
   logic       start_recover = 1'b0;
   logic       bit_tick = 1'b0;
   logic       rx_bit = 1'b0;
   logic       tec_lt96;
   logic       tec_ge96;
   logic       tec_ge128;
   logic       busoff;
   logic       busoff_done;
   logic [7:0] teccount;

   tec_busoff #(.RUN_LEN(RUN_LEN), .SEQ_LEN(SEQ_LEN)) dut (
      .clock         (clock),
      .reset         (reset),
      .incegttec     (incegttec),
      .dectec        (dectec),
      .start_recover (start_recover),
      .bit_tick      (bit_tick),
      .rx_bit        (rx_bit),
      .tec_lt96      (tec_lt96),
      .tec_ge96      (tec_ge96),
      .tec_ge128     (tec_ge128),
      .busoff        (busoff),
      .busoff_done   (busoff_done),
      .teccount      (teccount)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: recovery progress is the runs banked before the last dominant
   // bit plus whole runs inside the current recessive streak.
   int m_tec = 0;
   int m_streak = 0;
   int m_bank = 0;
   bit m_bo = 1'b0;
   bit m_rec = 1'b0;
   bit m_done = 1'b0;
   bit m_held = 1'b0;

   always @(posedge clock) begin : model
      bit act;
      act = incegttec | dectec;
      m_done = 1'b0;
      if (!reset) begin
         m_tec = 0; m_bo = 0; m_rec = 0; m_held = 0; m_streak = 0; m_bank = 0;
      end else begin
         if (!m_bo) begin
            if (act && !m_held) begin
               if (incegttec) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
               else if (m_tec > 0) m_tec = m_tec - 1;
            end
            if (m_tec >= 256) begin
               m_bo = 1; m_rec = 0;
            end
         end else if (!m_rec) begin
            if (start_recover) begin
               m_rec = 1; m_streak = 0; m_bank = 0;
            end
         end else if (!start_recover) begin
            m_rec = 0; m_streak = 0; m_bank = 0;
         end else if (bit_tick) begin
            if (rx_bit) begin
               m_streak++;
               if (m_bank + m_streak / RUN_LEN == SEQ_LEN) begin
                  m_tec = 0; m_bo = 0; m_rec = 0; m_done = 1;
                  m_streak = 0; m_bank = 0;
               end
            end else begin
               m_bank += m_streak / RUN_LEN;
               m_streak = 0;
            end
         end
         m_held = act;
      end
   end

   always @(negedge clock) begin
      if (chk_on) begin
         chk("teccount", int'(teccount), m_tec % 256);
         chk("lt96", int'(tec_lt96), (m_tec < 96) ? 1 : 0);
         chk("ge96", int'(tec_ge96), (m_tec >= 96) ? 1 : 0);
         chk("ge128", int'(tec_ge128), (m_tec >= 128) ? 1 : 0);
         chk("busoff", int'(busoff), int'(m_bo));
         chk("busoff_done", int'(busoff_done), int'(m_done));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse(input bit i, input bit d);
      incegttec = i; dectec = d;
      cyc(1);
      incegttec = 0; dectec = 0;
      cyc(1);
   endtask

   task automatic tick(input bit rx, input int idle);
      bit_tick = 1; rx_bit = rx;
      cyc(1);
      bit_tick = 0; rx_bit = 1'($urandom);
      cyc(idle);
   endtask

   task automatic ticks_rec(input int n);
      repeat (n) tick(1'b1, int'($urandom_range(0, 1)));
   endtask

   initial begin
      reset = 0;
      cyc(1);
      chk_on = 1;
      cyc(1);
      reset = 1;
      chk("rst_cnt", int'(teccount), 0);
      chk("rst_lt96", int'(tec_lt96), 1);
      chk("rst_busoff", int'(busoff), 0);

      repeat (12) pulse(1, 0);
      chk("cnt96", int'(teccount), 96);
      chk("ge96_at96", int'(tec_ge96), 1);
      chk("ge128_at96", int'(tec_ge128), 0);
      repeat (4) pulse(1, 0);
      chk("cnt128", int'(teccount), 128);
      chk("ge128_at128", int'(tec_ge128), 1);
      pulse(0, 1);
      chk("cnt127", int'(teccount), 127);
      chk("ge128_at127", int'(tec_ge128), 0);

      incegttec = 1; cyc(10); incegttec = 0; cyc(1);
      chk("held_inc", int'(teccount), 135);

      reset = 0; cyc(1); reset = 1;
      pulse(0, 1);
      chk("dec_at0", int'(teccount), 0);
      chk("lt96_at0", int'(tec_lt96), 1);
      pulse(1, 0); pulse(1, 0);
      repeat (6) pulse(0, 1);
      chk("cnt10", int'(teccount), 10);
      pulse(1, 1);
      chk("inc_prio", int'(teccount), 18);
      repeat (29) pulse(1, 0);
      chk("cnt250", int'(teccount), 250);
      incegttec = 1; cyc(1);
      chk("sat_busoff", int'(busoff), 1);
      chk("sat_tec", int'(teccount), 0);
      chk("sat_ge128", int'(tec_ge128), 1);
      incegttec = 0; cyc(1);
      repeat (3) pulse(1, 0);
      repeat (3) pulse(0, 1);
      chk("bo_ignore", int'(busoff), 1);

      // dominant after 10 recessive bits voids that run
      start_recover = 1; cyc(1);
      repeat (10) tick(1, 1);
      tick(0, 1);
      ticks_rec(1407);
      chk("bo_1407", int'(busoff), 1);
      tick(1, 0);
      chk("done_pulse", int'(busoff_done), 1);
      chk("done_busoff", int'(busoff), 0);
      chk("done_tec", int'(teccount), 0);
      cyc(1);
      chk("done_one", int'(busoff_done), 0);
      start_recover = 0;

      // abort at seq=50 then full restart
      repeat (32) pulse(1, 0);
      chk("bo2", int'(busoff), 1);
      start_recover = 1; cyc(1);
      ticks_rec(550);
      start_recover = 0; cyc(3);
      chk("abort_bo", int'(busoff), 1);
      start_recover = 1; cyc(1);
      ticks_rec(1407);
      chk("restart_1407", int'(busoff), 1);
      tick(1, 0);
      chk("restart_done", int'(busoff_done), 1);
      cyc(1);
      start_recover = 0;

      // reset at seq=100
      repeat (32) pulse(1, 0);
      start_recover = 1; cyc(1);
      ticks_rec(1100);
      reset = 0; cyc(1);
      chk("mid_rst_bo", int'(busoff), 0);
      chk("mid_rst_tec", int'(teccount), 0);
      chk("mid_rst_lt96", int'(tec_lt96), 1);
      reset = 1; start_recover = 0;
      cyc(1);

      repeat (9000) begin
         incegttec     = ($urandom_range(0, 3) == 0);
         dectec        = ($urandom_range(0, 5) == 0);
         start_recover = ($urandom_range(0, 4999) != 0);
         bit_tick      = 1'($urandom_range(0, 1));
         rx_bit        = ($urandom_range(0, 49) != 0);
         reset         = ($urandom_range(0, 3999) != 0);
         cyc(1);
      end
      reset = 1; incegttec = 0; dectec = 0; bit_tick = 0;
      cyc(2);
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tec_busoff
`default_nettype wire

// File: doc/tec_busoff.md
Name: tec_busoff

Overview:
- Transmit Error Counter with integrated bus-off recovery sequencer.
- Counts transmit errors (+8) and successful transmissions (−1) reported by the MAC FSM, and drives threshold flags (96 / 128 / 256) to faultfsm.
- On reaching 256 (bus-off), runs the recovery sequence: 128 occurrences of 11 consecutive recessive bits, then clears the counter.

Parameters:
- RUN_LEN, 11, consecutive recessive sampled bits forming one recovery occurrence (range 2..15)
- SEQ_LEN, 128, recovery occurrences required to leave bus-off (range 1..255)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low; from resetgen ORed with faultfsm
- incegttec  input  1  MAC FSM: transmit error, +8
- dectec  input  1  MAC FSM: successful transmission, −1
- start_recover  input  1  faultfsm/host: permission to start recovery while bus-off (level)
- bit_tick  input  1  one-cycle strobe at each bit sample point
- rx_bit  input  1  sampled bus level at bit_tick (1 = recessive)
- tec_lt96  output  1  counter < 96
- tec_ge96  output  1  counter ≥ 96
- tec_ge128  output  1  counter ≥ 128 (error passive)
- busoff  output  1  FSM in BUSOFF_WAIT or BUSOFF_RECOVER
- busoff_done  output  1  one-cycle pulse when recovery completes
- teccount  output  8  counter[7:0]; reads 0 while bus-off

Behaviour:
- Reset (reset=0 at a clock edge):
  - counter=0, edge marker=0, FSM=NORMAL, run=0, seq=0, busoff_done=0.
  - Flags after reset: lt96=1, ge96=0, ge128=0, busoff=0.
- counter is 9 bits.
- Edge marker (deglitch): action = incegttec | dectec.
  - The counter updates only in the first cycle of a high action; the marker is set then.
  - The marker clears in the first cycle with action=0.
  - A held request counts once.
- NORMAL state, first action cycle:
  - incegttec=1 → counter+8. This has priority over a simultaneous dectec; dectec is then dropped.
  - dectec alone → counter−1 if counter≠0; at 0 it holds 0.
  - Result ≥256 → counter forced to 256, FSM → BUSOFF_WAIT in the same edge.
- Flags are combinational from the counter:
  - >255 → lt96=0, ge96=1, ge128=1.
  - 128..255 → 0,1,1.
  - 96..127 → 0,1,0.
  - else → 1,0,0.
- busoff = (FSM ≠ NORMAL), registered with the FSM state.
- BUSOFF_WAIT:
  - incegttec and dectec are ignored; the edge marker still tracks them.
  - start_recover=1 → BUSOFF_RECOVER, run=0, seq=0.
- BUSOFF_RECOVER, on each bit_tick:
  - rx_bit=0 → run=0.
  - rx_bit=1 → run+1. When run reaches RUN_LEN−1 and rx_bit=1: run=0, seq+1 (a 12th recessive bit starts a new run).
  - When seq would reach SEQ_LEN: counter=0, run=0, seq=0, FSM → NORMAL, busoff_done=1 for exactly that next cycle.
  - start_recover deassert mid-recovery → back to BUSOFF_WAIT, run=0, seq=0.
- No bit_tick → no change to run or seq.
- Reset mid-recovery: full reset; the block comes up in NORMAL with counter=0.
- teccount: counter[7:0]. At 256 this reads 0, and ge128=1 distinguishes it from a true 0.
- Latency: the counter updates 1 clock after the request edge. Flags follow combinationally from the registered counter.
- No counter wrap in any state. Increments from 249..255 saturate to 256.

Decomposition:
- Shared package:
  - FSM state encoding: NORMAL=2'b00, BUSOFF_WAIT=2'b01, BUSOFF_RECOVER=2'b10.
  - Threshold constants 96, 128, 256.
  - Increment constant 8.
- One natural sub-module: busoff_seq_cnt.
  - Contains the run/seq counters, taking RUN_LEN and SEQ_LEN.
  - Inputs: enable, clear, bit_tick, rx_bit. Output: done.
- The TEC counter, edge marker and FSM stay in tec_busoff.

Test Plan:
- Reset, then 12 single-cycle incegttec pulses → counter=96 (lt96=0, ge96=1, ge128=0); 4 more → 128, ge128=1; one dectec → 127, ge128=0.
- incegttec held high for 10 cycles → counter increases by 8 only once. Simultaneous incegttec+dectec at counter=10 → 18.
- dectec at counter=0 → stays 0, lt96=1. Counter 250 + incegttec → 256: busoff=1 next cycle, teccount=0, ge128=1; further inc/dec ignored.
- busoff with start_recover=1, RUN_LEN=11, SEQ_LEN=128:
  - 1408 consecutive recessive bit_ticks → busoff_done pulse 1 cycle, counter=0, busoff=0.
  - After only 1407 ticks, still busoff.
- During recovery, a dominant bit after 10 recessive bits → that run does not count. Deasserting start_recover at seq=50 → BUSOFF_WAIT, and re-entry requires a full 128 runs.
- reset=0 at seq=100 → all outputs at reset values next cycle.
